// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit: scoreboard entry layout,
// forwarding-select encodings and the per-operand forwarding priority helper.
package hazard_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int FWD_W      = 2;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EX  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr_en;
    logic                  is_load;
    logic                  sets_flags;
  } sb_entry_t;

  function automatic logic sb_match(input sb_entry_t e, input logic [REG_ADDR_W-1:0] rs);
    return e.valid & e.wr_en & (e.rd == rs);
  endfunction

  // A load in EX has no data yet, so it is skipped here and handled as a load-use stall.
  function automatic logic [FWD_W-1:0] fwd_select(input sb_entry_t ex, input sb_entry_t mem,
                                                   input sb_entry_t wb,
                                                   input logic [REG_ADDR_W-1:0] rs,
                                                   input logic used);
    logic [FWD_W-1:0] sel;
    sel = FWD_RF;
    if (used) begin
      if (sb_match(ex, rs) && !ex.is_load) sel = FWD_EX;
      else if (sb_match(mem, rs))          sel = FWD_MEM;
      else if (sb_match(wb, rs))           sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-deep shift register tracking the instructions in EX, MEM and WB.
// A bubble loads an empty entry into EX; reset clears every entry asynchronously.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_bubble,
  input  sb_entry_t i_id,
  output sb_entry_t o_ex,
  output sb_entry_t o_mem,
  output sb_entry_t o_wb
);

  sb_entry_t r_ex;
  sb_entry_t r_mem;
  sb_entry_t r_wb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= i_bubble ? '0 : i_id;
    end
  end

  assign o_ex  = r_ex;
  assign o_mem = r_mem;
  assign o_wb  = r_wb;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Forwarding, load-use/flag stall and branch-flush control for the 5-stage pipeline.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module pipeline_hazard_unit
  import hazard_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic                  id_rs1_used,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wr_en,
  input  logic                  id_is_load,
  input  logic                  id_sets_flags,
  input  logic                  id_uses_flags,
  input  logic                  ex_branch_taken,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic [FWD_W-1:0]      fwd_a_sel,
  output logic [FWD_W-1:0]      fwd_b_sel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           flush_cnt
`endif
);

  sb_entry_t w_id_entry;
  sb_entry_t w_ex;
  sb_entry_t w_mem;
  sb_entry_t w_wb;
  logic      w_load_use;
  logic      w_flag_hazard;
  logic      w_hazard;
  logic      w_stall;
  logic      w_flush_if_id;
  logic      w_flush_id_ex;
  logic      w_bubble;

  assign w_id_entry = '{valid:      id_valid,
                        rd:         id_rd,
                        wr_en:      id_wr_en,
                        is_load:    id_is_load,
                        sets_flags: id_sets_flags};

  hazard_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .i_bubble (w_bubble),
    .i_id     (w_id_entry),
    .o_ex     (w_ex),
    .o_mem    (w_mem),
    .o_wb     (w_wb)
  );

  assign w_load_use = id_valid & w_ex.is_load &
                      ((id_rs1_used & sb_match(w_ex, id_rs1)) |
                       (id_rs2_used & sb_match(w_ex, id_rs2)));

  // Flags are only committed at the end of EX, so a flag producer in EX cannot be bypassed.
  assign w_flag_hazard = id_valid & id_uses_flags & w_ex.valid & w_ex.sets_flags;
  assign w_hazard      = w_load_use | w_flag_hazard;

  // A taken branch squashes the ID instruction, so any stall it would have caused is moot.
  assign w_stall       = w_hazard & ~ex_branch_taken;
  assign w_flush_if_id = ex_branch_taken;
  assign w_flush_id_ex = ex_branch_taken | w_hazard;
  assign w_bubble      = ~id_valid | w_stall | w_flush_id_ex;

  always_comb begin
    stall       = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    fwd_a_sel   = FWD_RF;
    fwd_b_sel   = FWD_RF;
    if (!rst) begin
      stall       = w_stall;
      flush_if_id = w_flush_if_id;
      flush_id_ex = w_flush_id_ex;
      fwd_a_sel   = fwd_select(w_ex, w_mem, w_wb, id_rs1, id_rs1_used);
      fwd_b_sel   = fwd_select(w_ex, w_mem, w_wb, id_rs2, id_rs2_used);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && r_stall_cnt != 16'hFFFF)       r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush_if_id && r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: directed hazard scenarios followed by random traffic,
// all compared against a list-of-in-flight-instructions reference model.
module tb_pipeline_hazard_unit;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_rs1;
  logic       id_rs1_used;
  logic [2:0] id_rs2;
  logic       id_rs2_used;
  logic [2:0] id_rd;
  logic       id_wr_en;
  logic       id_is_load;
  logic       id_sets_flags;
  logic       id_uses_flags;
  logic       ex_branch_taken;
  logic       stall;
  logic       flush_if_id;
  logic       flush_id_ex;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  pipeline_hazard_unit dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs1_used     (id_rs1_used),
    .id_rs2          (id_rs2),
    .id_rs2_used     (id_rs2_used),
    .id_rd           (id_rd),
    .id_wr_en        (id_wr_en),
    .id_is_load      (id_is_load),
    .id_sets_flags   (id_sets_flags),
    .id_uses_flags   (id_uses_flags),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------- reference model ----------------
  // pipe[0] is the instruction now in EX, pipe[1] in MEM, pipe[2] in WB.
  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
    bit sf;
  } instr_t;

  instr_t pipe[3];
  int     m_stall_cnt;
  int     m_flush_cnt;

  // Sampled DUT outputs from the latest cycle, for directed checks.
  logic       s_stall, s_fii, s_fie;
  logic [1:0] s_fa, s_fb;
  logic [15:0] s_scnt, s_fcnt;

  function automatic void model_clear();
    for (int k = 0; k < 3; k++) pipe[k] = '{v: 0, rd: 0, wr: 0, ld: 0, sf: 0};
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endfunction

  // Youngest in-flight writer that can supply the value wins; a load still in EX cannot.
  function automatic int m_fwd(input int rs, input bit used);
    if (!used) return 0;
    for (int k = 0; k < 3; k++)
      if (pipe[k].v && pipe[k].wr && pipe[k].rd == rs && !(k == 0 && pipe[k].ld))
        return k + 1;
    return 0;
  endfunction

  function automatic bit m_load_hit(input int rs, input bit used);
    return used && pipe[0].v && pipe[0].wr && pipe[0].ld && pipe[0].rd == rs;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit wr, input bit ld, input bit sf, input bit uf,
                       input bit br);
    id_valid        = v;
    id_rs1          = 3'(rs1);
    id_rs1_used     = u1;
    id_rs2          = 3'(rs2);
    id_rs2_used     = u2;
    id_rd           = 3'(rd);
    id_wr_en        = wr;
    id_is_load      = ld;
    id_sets_flags   = sf;
    id_uses_flags   = uf;
    ex_branch_taken = br;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: check outputs at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    int ea, eb;
    bit hz, es, efi, efe;
    @(negedge clk);
    if (rst) begin
      model_clear();
      ea = 0; eb = 0; hz = 0; es = 0; efi = 0; efe = 0;
    end else begin
      ea  = m_fwd(int'(id_rs1), id_rs1_used);
      eb  = m_fwd(int'(id_rs2), id_rs2_used);
      hz  = id_valid && (m_load_hit(int'(id_rs1), id_rs1_used) ||
                         m_load_hit(int'(id_rs2), id_rs2_used) ||
                         (id_uses_flags && pipe[0].v && pipe[0].sf));
      es  = hz && !ex_branch_taken;
      efi = ex_branch_taken;
      efe = ex_branch_taken || hz;
    end
    s_stall = stall; s_fii = flush_if_id; s_fie = flush_id_ex; s_fa = fwd_a_sel; s_fb = fwd_b_sel;
    check("stall",       16'(stall),       16'(es));
    check("flush_if_id", 16'(flush_if_id), 16'(efi));
    check("flush_id_ex", 16'(flush_id_ex), 16'(efe));
    check("fwd_a_sel",   16'(fwd_a_sel),   16'(ea));
    check("fwd_b_sel",   16'(fwd_b_sel),   16'(eb));
`ifdef HAZARD_PERF_CNT_EN
    s_scnt = stall_cnt; s_fcnt = flush_cnt;
    check("stall_cnt", stall_cnt, 16'(m_stall_cnt));
    check("flush_cnt", flush_cnt, 16'(m_flush_cnt));
`else
    s_scnt = 16'd0; s_fcnt = 16'd0;
`endif
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (es  && m_stall_cnt < 65535) m_stall_cnt++;
      if (efi && m_flush_cnt < 65535) m_flush_cnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (id_valid && !efe)
        pipe[0] = '{v: 1, rd: int'(id_rd), wr: id_wr_en, ld: id_is_load, sf: id_sets_flags};
      else
        pipe[0] = '{v: 0, rd: 0, wr: 0, ld: 0, sf: 0};
    end
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      nop();
      cycle();
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    nop();
    cycle();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    rst = 1'b1;
    // Hazard-shaped inputs during reset: every output must still be held at 0.
    drive(1, 1, 1, 2, 1, 3, 1, 1, 1, 1, 1);
    cycle();
    check("rst_stall", 16'(s_stall), 16'd0);
    check("rst_flush", 16'(s_fii),   16'd0);
    rst = 1'b0;
    nops(1);

    // 1: back-to-back dependency forwards from EX/MEM
    drive(1, 3, 1, 4, 1, 1, 1, 0, 0, 0, 0); cycle();
    drive(1, 1, 1, 3, 1, 2, 1, 0, 0, 0, 0); cycle();
    check("t1_fwd_a", 16'(s_fa), 16'd1);
    check("t1_stall", 16'(s_stall), 16'd0);
    nops(3);

    // 2: distance 2 -> MEM/WB, distance 3 -> WB
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); cycle();
    nops(1);
    drive(1, 1, 1, 1, 1, 4, 1, 0, 0, 0, 0); cycle();
    check("t2_fwd_a10", 16'(s_fa), 16'd2);
    check("t2_fwd_b10", 16'(s_fb), 16'd2);
    nops(3);
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); cycle();
    nops(2);
    drive(1, 1, 1, 1, 1, 4, 1, 0, 0, 0, 0); cycle();
    check("t2_fwd_a11", 16'(s_fa), 16'd3);
    check("t2_fwd_b11", 16'(s_fb), 16'd3);
    nops(3);

    // 3: load-use stall for exactly one cycle, then MEM forward
    drive(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0); cycle();
    drive(1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0); cycle();
    check("t3_stall",   16'(s_stall), 16'd1);
    check("t3_flushex", 16'(s_fie),   16'd1);
    cycle();
    check("t3_fwd_a", 16'(s_fa),    16'd2);
    check("t3_nostall", 16'(s_stall), 16'd0);
    nops(3);

    // 4: flag stall, then branch overriding a load-use hazard
    drive(1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0); cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
    check("t4_flag_stall", 16'(s_stall), 16'd1);
    cycle();
    check("t4_flag_release", 16'(s_stall), 16'd0);
    nops(3);
    drive(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0); cycle();
    drive(1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 1); cycle();
    check("t4_br_stall", 16'(s_stall), 16'd0);
    check("t4_br_fii",   16'(s_fii),   16'd1);
    check("t4_br_fie",   16'(s_fie),   16'd1);
    nops(3);

    // 5: reset mid-stream empties the pipeline
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0); cycle();
    end
    pulse_reset();
    drive(1, 2, 1, 2, 1, 3, 1, 0, 0, 0, 0); cycle();
    check("t5_fwd_a", 16'(s_fa), 16'd0);
    check("t5_fwd_b", 16'(s_fb), 16'd0);
    check("t5_stall", 16'(s_stall), 16'd0);
    nops(3);

`ifdef HAZARD_PERF_CNT_EN
    // 6: three load-use stalls and two taken branches
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0); cycle();
      drive(1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0); cycle();
      cycle();
      nops(2);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    nops(1);
    check("t6_stall_cnt", s_scnt, 16'd3);
    check("t6_flush_cnt", s_fcnt, 16'd2);
`endif

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 7) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      cycle();
    end
    rst = 1'b0;
    nops(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
